// File: rtl/bcd_stopwatch_ctrl_if.sv
// Command and readout bundle for the BCD stopwatch controller.
// The master issues one-cycle commands; the slave drives the live count, lap snapshot and flags.
interface bcd_stopwatch_ctrl_if #(
   parameter int DIGITS = 4
);
   logic                  start;
   logic                  stop;
   logic                  clear;
   logic                  lap;
   logic                  running;
   logic                  tick;
   logic [4*DIGITS-1:0]   bcd;
   logic [4*DIGITS-1:0]   lap_bcd;
   logic                  lap_valid;
   logic                  ovf;

   modport master (
      output start, stop, clear, lap,
      input  running, tick, bcd, lap_bcd, lap_valid, ovf
   );

   modport slave (
      input  start, stop, clear, lap,
      output running, tick, bcd, lap_bcd, lap_valid, ovf
   );
endinterface

// File: rtl/bcd_stopwatch_ctrl.sv
// Multi-digit BCD stopwatch: prescaled tick, same-edge carry ripple across digits,
// start/stop/clear state machine, lap snapshots and a sticky overflow flag.
module bcd_stopwatch_ctrl #(
   parameter int DIGITS   = 4,
   parameter int TICK_DIV = 10
) (
   input  logic                 clk,
   input  logic                 rstn,
   bcd_stopwatch_ctrl_if.slave  bus
);
   localparam int W  = 4 * DIGITS;
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      PAUSE
   } state_t;

   state_t          state;
   state_t          next_state;
   logic [PW-1:0]   prescaler;
   logic [PW-1:0]   next_prescaler;
   logic [W-1:0]    count;
   logic [W-1:0]    count_inc;
   logic [W-1:0]    lap_count;
   logic            lap_pulse;
   logic            ovf_flag;
   logic            all_nines;
   logic            carry;
   logic            tick_now;
   logic            lap_take;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         prescaler <= '0;
      end else begin
         state     <= next_state;
         prescaler <= next_prescaler;
      end
   end

   // clear beats stop beats start; stop+start in PAUSE therefore stays paused
   always_comb begin
      next_state = state;
      if (bus.clear) begin
         next_state = IDLE;
      end else begin
         case (state)
            IDLE:    if (bus.start) next_state = RUN;
            RUN:     if (bus.stop) next_state = PAUSE;
            PAUSE:   if (bus.start && !bus.stop) next_state = RUN;
            default: next_state = IDLE;
         endcase
      end
   end

   assign tick_now = (state == RUN) && (prescaler == PRE_LAST) && !bus.stop && !bus.clear;

   // A stop edge freezes the prescaler too, so a resume picks up the exact elapsed phase
   always_comb begin
      next_prescaler = prescaler;
      if (bus.clear || (state == IDLE)) begin
         next_prescaler = '0;
      end else if ((state == RUN) && !bus.stop) begin
         next_prescaler = (prescaler == PRE_LAST) ? '0 : prescaler + PW'(1);
      end
   end

   always_comb begin
      count_inc = count;
      carry     = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
         if (carry) begin
            if (count[4*k +: 4] == 4'd9) begin
               count_inc[4*k +: 4] = 4'd0;
            end else begin
               count_inc[4*k +: 4] = count[4*k +: 4] + 4'd1;
               carry               = 1'b0;
            end
         end
      end
      all_nines = carry;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count    <= '0;
         ovf_flag <= 1'b0;
      end else if (bus.clear) begin
         count    <= '0;
         ovf_flag <= 1'b0;
      end else if (tick_now) begin
         count <= count_inc;
         if (all_nines) ovf_flag <= 1'b1;
      end
   end

   // Snapshot takes the pre-increment count when lap and tick coincide
   assign lap_take = bus.lap && !bus.clear && (state != IDLE);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         lap_count <= '0;
         lap_pulse <= 1'b0;
      end else begin
         lap_pulse <= lap_take;
         if (lap_take) lap_count <= count;
      end
   end

   assign bus.running   = (state == RUN);
   assign bus.tick      = tick_now;
   assign bus.bcd       = count;
   assign bus.lap_bcd   = lap_count;
   assign bus.lap_valid = lap_pulse;
   assign bus.ovf       = ovf_flag;
endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Bench for bcd_stopwatch_ctrl: a 2-digit/div-2 instance driven from a vector table and
// hand sequences, plus a 4-digit/div-10 instance for the long carry ripple.
module tb_bcd_stopwatch_ctrl;
   logic clk = 1'b0;
   logic rstn;

   always #5 clk = ~clk;

   bcd_stopwatch_ctrl_if #(.DIGITS(2)) bus_a ();
   bcd_stopwatch_ctrl_if #(.DIGITS(4)) bus_b ();

   bcd_stopwatch_ctrl #(.DIGITS(2), .TICK_DIV(2))  dut_a (.clk(clk), .rstn(rstn), .bus(bus_a));
   bcd_stopwatch_ctrl #(.DIGITS(4), .TICK_DIV(10)) dut_b (.clk(clk), .rstn(rstn), .bus(bus_b));

   typedef struct {
      logic        start;
      logic        stop;
      logic        clear;
      logic        lap;
      logic        exp_tick;
      logic        exp_running;
      logic [15:0] exp_bcd;
      logic [15:0] exp_lap_bcd;
      logic        exp_lap_valid;
      logic        exp_ovf;
   } vec_t;

   vec_t sb_q[$];
   vec_t tbl[24];
   int   checks = 0;
   int   errors = 0;
   logic tick_seen;

   int   m_pre[2];
   int   m_cnt[2];
   int   m_lap[2];
   logic m_ovf[2];
   int   m_td[2]  = '{2, 10};
   int   m_dig[2] = '{2, 4};
   int   m_mod[2] = '{100, 10000};

   function automatic vec_t mk(input logic s, input logic p, input logic c, input logic l,
                               input logic t, input logic r, input logic [15:0] b,
                               input logic [15:0] lb, input logic lv, input logic o);
      vec_t v;
      v.start = s; v.stop = p; v.clear = c; v.lap = l;
      v.exp_tick = t; v.exp_running = r; v.exp_bcd = b; v.exp_lap_bcd = lb;
      v.exp_lap_valid = lv; v.exp_ovf = o;
      return v;
   endfunction

   function automatic logic [15:0] to_bcd(input int n, input int dig);
      logic [15:0] r;
      int          v;
      r = '0;
      v = n;
      for (int k = 0; k < dig; k++) begin
         r[4*k +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   task automatic drive_cmds(input bit sel, input logic s, input logic p, input logic c, input logic l);
      bus_a.start = sel ? 1'b0 : s;
      bus_a.stop  = sel ? 1'b0 : p;
      bus_a.clear = sel ? 1'b0 : c;
      bus_a.lap   = sel ? 1'b0 : l;
      bus_b.start = sel ? s : 1'b0;
      bus_b.stop  = sel ? p : 1'b0;
      bus_b.clear = sel ? c : 1'b0;
      bus_b.lap   = sel ? l : 1'b0;
   endtask

   task automatic applyStimulus(input vec_t v, input bit sel);
      @(negedge clk);
      drive_cmds(sel, v.start, v.stop, v.clear, v.lap);
      sb_q.push_back(v);
      #1;
      tick_seen = sel ? bus_b.tick : bus_a.tick;
   endtask

   task automatic checkOutput(input bit sel, input string tag);
      vec_t        e;
      logic        got_run, got_lv, got_ovf;
      logic [15:0] got_bcd, got_lap;
      @(posedge clk);
      #1;
      checks++;
      if (sb_q.size() == 0) begin
         errors++;
         $display("[TB] FAIL %s: scoreboard empty, got output with no expectation", tag);
      end else begin
         e = sb_q.pop_front();
         if (sel) begin
            got_run = bus_b.running; got_lv = bus_b.lap_valid; got_ovf = bus_b.ovf;
            got_bcd = bus_b.bcd;     got_lap = bus_b.lap_bcd;
         end else begin
            got_run = bus_a.running;         got_lv = bus_a.lap_valid; got_ovf = bus_a.ovf;
            got_bcd = {8'h00, bus_a.bcd};    got_lap = {8'h00, bus_a.lap_bcd};
         end
         if (tick_seen !== e.exp_tick || got_run !== e.exp_running || got_bcd !== e.exp_bcd ||
             got_lap !== e.exp_lap_bcd || got_lv !== e.exp_lap_valid || got_ovf !== e.exp_ovf) begin
            errors++;
            $display("[TB] FAIL %s: got tick=%b run=%b bcd=%h lap=%h lv=%b ovf=%b, want tick=%b run=%b bcd=%h lap=%h lv=%b ovf=%b",
                     tag, tick_seen, got_run, got_bcd, got_lap, got_lv, got_ovf,
                     e.exp_tick, e.exp_running, e.exp_bcd, e.exp_lap_bcd, e.exp_lap_valid, e.exp_ovf);
         end
      end
   endtask

   task automatic step(input vec_t v, input bit sel, input string tag);
      applyStimulus(v, sel);
      checkOutput(sel, tag);
   endtask

   task automatic expect16(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, want %h", tag, got, exp);
      end
   endtask

   // Free-running RUN cycles with no commands, expectations from a decimal counter model
   task automatic run(input bit sel, input int n, input string tag);
      logic t;
      for (int i = 0; i < n; i++) begin
         t = (m_pre[sel] == m_td[sel] - 1);
         if (t) begin
            m_cnt[sel]++;
            if (m_cnt[sel] == m_mod[sel]) begin
               m_cnt[sel] = 0;
               m_ovf[sel] = 1'b1;
            end
         end
         m_pre[sel] = t ? 0 : m_pre[sel] + 1;
         step(mk(0, 0, 0, 0, t, 1, to_bcd(m_cnt[sel], m_dig[sel]),
                 to_bcd(m_lap[sel], m_dig[sel]), 0, m_ovf[sel]), sel, tag);
      end
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rstn = 1'b0;
      drive_cmds(1'b0, 0, 0, 0, 0);
      for (int s = 0; s < 2; s++) begin
         m_pre[s] = 0; m_cnt[s] = 0; m_lap[s] = 0; m_ovf[s] = 1'b0;
      end

      tbl[0]  = mk(0, 0, 0, 0, 0, 0, 16'h00, 16'h00, 0, 0);
      tbl[1]  = mk(0, 0, 0, 1, 0, 0, 16'h00, 16'h00, 0, 0);
      tbl[2]  = mk(1, 0, 0, 0, 0, 1, 16'h00, 16'h00, 0, 0);
      tbl[3]  = mk(0, 0, 0, 0, 0, 1, 16'h00, 16'h00, 0, 0);
      tbl[4]  = mk(0, 0, 0, 0, 1, 1, 16'h01, 16'h00, 0, 0);
      tbl[5]  = mk(0, 0, 0, 0, 0, 1, 16'h01, 16'h00, 0, 0);
      tbl[6]  = mk(0, 1, 0, 0, 0, 0, 16'h01, 16'h00, 0, 0);
      tbl[7]  = mk(0, 0, 0, 0, 0, 0, 16'h01, 16'h00, 0, 0);
      tbl[8]  = mk(0, 0, 0, 1, 0, 0, 16'h01, 16'h01, 1, 0);
      tbl[9]  = mk(1, 0, 0, 0, 0, 1, 16'h01, 16'h01, 0, 0);
      tbl[10] = mk(0, 0, 0, 0, 1, 1, 16'h02, 16'h01, 0, 0);
      tbl[11] = mk(0, 0, 0, 1, 0, 1, 16'h02, 16'h02, 1, 0);
      tbl[12] = mk(0, 0, 0, 1, 1, 1, 16'h03, 16'h02, 1, 0);
      tbl[13] = mk(0, 0, 0, 0, 0, 1, 16'h03, 16'h02, 0, 0);
      tbl[14] = mk(1, 1, 0, 0, 0, 0, 16'h03, 16'h02, 0, 0);
      tbl[15] = mk(1, 1, 0, 0, 0, 0, 16'h03, 16'h02, 0, 0);
      tbl[16] = mk(1, 0, 0, 0, 0, 1, 16'h03, 16'h02, 0, 0);
      tbl[17] = mk(0, 0, 1, 1, 0, 0, 16'h00, 16'h02, 0, 0);
      tbl[18] = mk(1, 0, 0, 0, 0, 1, 16'h00, 16'h02, 0, 0);
      tbl[19] = mk(0, 0, 0, 0, 0, 1, 16'h00, 16'h02, 0, 0);
      tbl[20] = mk(0, 0, 0, 0, 1, 1, 16'h01, 16'h02, 0, 0);
      tbl[21] = mk(1, 1, 1, 0, 0, 0, 16'h00, 16'h02, 0, 0);
      tbl[22] = mk(0, 1, 0, 0, 0, 0, 16'h00, 16'h02, 0, 0);
      tbl[23] = mk(1, 0, 0, 0, 0, 1, 16'h00, 16'h02, 0, 0);

      #7;
      expect16("reset_state_a", {bus_a.running, bus_a.tick, bus_a.lap_valid, bus_a.ovf, bus_a.lap_bcd, bus_a.bcd},
               16'h0000);
      expect16("reset_state_b", bus_b.bcd, 16'h0000);
      @(negedge clk);
      rstn = 1'b1;

      $display("[TB] vector table on 2-digit instance");
      for (int i = 0; i < 24; i++) step(tbl[i], 1'b0, $sformatf("vec%0d", i));

      m_pre[0] = 0; m_cnt[0] = 0; m_lap[0] = 2; m_ovf[0] = 1'b0;
      run(1'b0, 20, "basic_count");
      expect16("basic_count_0x10", {8'h00, bus_a.bcd}, 16'h0010);
      run(1'b0, 178, "count_to_99");
      expect16("reached_0x99", {8'h00, bus_a.bcd}, 16'h0099);
      run(1'b0, 2, "overflow_tick");
      expect16("overflow_wrap", {7'h00, bus_a.ovf, bus_a.bcd}, 16'h0100);
      run(1'b0, 2, "after_overflow");
      expect16("ovf_sticky", {7'h00, bus_a.ovf, bus_a.bcd}, 16'h0101);
      step(mk(0, 0, 1, 0, 0, 0, 16'h00, 16'h02, 0, 0), 1'b0, "clear_after_ovf");
      m_pre[0] = 0; m_cnt[0] = 0; m_ovf[0] = 1'b0;

      $display("[TB] pause/resume");
      step(mk(1, 0, 0, 0, 0, 1, 16'h00, 16'h02, 0, 0), 1'b0, "start_pause_test");
      run(1'b0, 11, "run_to_05");
      step(mk(0, 1, 0, 0, 0, 0, 16'h05, 16'h02, 0, 0), 1'b0, "stop_on_tick_edge");
      for (int i = 0; i < 10; i++) step(mk(0, 0, 0, 0, 0, 0, 16'h05, 16'h02, 0, 0), 1'b0, "paused_hold");
      step(mk(1, 0, 0, 0, 0, 1, 16'h05, 16'h02, 0, 0), 1'b0, "resume");
      run(1'b0, 1, "first_edge_after_resume");
      expect16("resume_0x06", {8'h00, bus_a.bcd}, 16'h0006);

      $display("[TB] lap on tick cycle");
      step(mk(0, 0, 1, 0, 0, 0, 16'h00, 16'h02, 0, 0), 1'b0, "clear_before_lap");
      m_pre[0] = 0; m_cnt[0] = 0;
      step(mk(1, 0, 0, 0, 0, 1, 16'h00, 16'h02, 0, 0), 1'b0, "start_lap_test");
      run(1'b0, 85, "run_to_42");
      step(mk(0, 0, 0, 1, 1, 1, 16'h43, 16'h42, 1, 0), 1'b0, "lap_with_tick");
      m_pre[0] = 0; m_cnt[0] = 43; m_lap[0] = 42;
      run(1'b0, 1, "lap_valid_drops");
      expect16("lap_bcd_0x42", {8'h00, bus_a.lap_bcd}, 16'h0042);
      step(mk(0, 0, 1, 0, 0, 0, 16'h00, 16'h42, 0, 0), 1'b0, "clear_keeps_lap");
      m_pre[0] = 0; m_cnt[0] = 0;

      $display("[TB] 4-digit ripple carry");
      step(mk(1, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0), 1'b1, "start_b");
      run(1'b1, 9990, "count_b");
      expect16("b_0999", bus_b.bcd, 16'h0999);
      run(1'b1, 10, "ripple_b");
      expect16("b_1000", bus_b.bcd, 16'h1000);
      step(mk(0, 0, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0), 1'b1, "clear_b");

      $display("[TB] asynchronous reset mid-run");
      step(mk(1, 0, 0, 0, 0, 1, 16'h00, 16'h42, 0, 0), 1'b0, "start_reset_test");
      run(1'b0, 74, "run_to_37");
      expect16("reached_0x37", {8'h00, bus_a.bcd}, 16'h0037);
      #2;
      rstn = 1'b0;
      #1;
      expect16("async_reset_a", {bus_a.running, bus_a.ovf, bus_a.lap_valid, 5'd0, bus_a.bcd}, 16'h0000);
      expect16("async_reset_lap", {8'h00, bus_a.lap_bcd}, 16'h0000);
      @(negedge clk);
      rstn = 1'b1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
